// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP32 register-to-register sequencer.
// FP_SEQ_VERIFY_EN adds the VERIFY state to the state enum.
package fp_seq_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned SIGN_BIT = 31;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO = 32'h4000_0000;

`ifdef FP_SEQ_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_A   = 3'd1,
        S_RD_B   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_VERIFY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;
`endif

    // Subtract is an add with operand B's sign inverted; all other bits pass untouched.
    function automatic logic [31:0] fp_flip_sign(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        r           = v;
        r[SIGN_BIT] = v[SIGN_BIT] ^ neg;
        return r;
    endfunction

endpackage

// File: rtl/fp_seq_ctrl_if.sv
// Command, register-bank and adder signals of the FP32 sequencer.
// slave = the controller, master = command source plus bank/adder environment.
interface fp_seq_ctrl_if
    import fp_seq_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [AW-1:0] cmd_rd;
    logic          cmd_sub;
    logic          busy;
    logic          done;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdata;
    logic          bank_we;
    logic          bank_mode;
    logic [DW-1:0] bank_rdata;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic [DW-1:0] add_sum;
    logic          wb_match;

    modport slave (
        input  cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_sub, bank_rdata, add_sum,
        output cmd_ready, busy, done, bank_addr, bank_wdata, bank_we, bank_mode,
               add_a, add_b, wb_match
    );

    modport master (
        output cmd_valid, cmd_rs1, cmd_rs2, cmd_rd, cmd_sub, bank_rdata, add_sum,
        input  cmd_ready, busy, done, bank_addr, bank_wdata, bank_we, bank_mode,
               add_a, add_b, wb_match
    );

endinterface

// File: rtl/fp_seq_wait_cnt.sv
// Read-latency wait counter: counts while i_run, flags LAT, then wraps to zero.
module fp_seq_wait_cnt #(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_term_c
);

    logic [CW-1:0] r_cnt;

    assign o_term_c = (r_cnt == CW'(LAT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_run || o_term_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fp_seq_ctrl.sv
// Sequencer for one FP32 op rd <= rs1 +/- rs2: two bank reads, adder, write-back.
// FP_SEQ_VERIFY_EN: read back rd after the write and report it on wb_match.
module fp_seq_ctrl
    import fp_seq_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fp_seq_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(RD_LAT + 1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_rs2, w_rs2_nxt;
    logic [AW-1:0] r_rd, w_rd_nxt;
    logic          r_sub, w_sub_nxt;
    logic          r_ready, w_ready_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_we, w_we_nxt;
    logic          r_mode, w_mode_nxt;
    logic [DW-1:0] r_add_a, w_add_a_nxt;
    logic [DW-1:0] r_add_b, w_add_b_nxt;
    logic          w_wait;
    logic          w_term;
`ifdef FP_SEQ_VERIFY_EN
    logic          r_match, w_match_nxt;
`endif

    fp_seq_wait_cnt #(
        .LAT (RD_LAT),
        .CW  (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_run    (w_wait),
        .o_term_c (w_term)
    );

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rs2_nxt   = r_rs2;
        w_rd_nxt    = r_rd;
        w_sub_nxt   = r_sub;
        w_done_nxt  = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = r_we;
        w_mode_nxt  = r_mode;
        w_add_a_nxt = r_add_a;
        w_add_b_nxt = r_add_b;
        w_wait      = 1'b0;
`ifdef FP_SEQ_VERIFY_EN
        w_match_nxt = r_match;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_ready) begin
                    w_rs2_nxt   = bus.cmd_rs2;
                    w_rd_nxt    = bus.cmd_rd;
                    w_sub_nxt   = bus.cmd_sub;
                    w_addr_nxt  = bus.cmd_rs1;
                    w_state_nxt = S_RD_A;
`ifdef FP_SEQ_VERIFY_EN
                    w_match_nxt = 1'b0;
`endif
                end
            end
            S_RD_A: begin
                w_wait = 1'b1;
                if (w_term) begin
                    w_add_a_nxt = bus.bank_rdata;
                    w_addr_nxt  = r_rs2;
                    w_state_nxt = S_RD_B;
                end
            end
            S_RD_B: begin
                w_wait = 1'b1;
                if (w_term) begin
                    w_add_b_nxt = fp_flip_sign(bus.bank_rdata, r_sub);
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_wdata_nxt = bus.add_sum;
                w_addr_nxt  = r_rd;
                w_we_nxt    = 1'b1;
                w_mode_nxt  = 1'b0;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                // The bank commits the write on this edge; close the write window.
                w_we_nxt   = 1'b0;
                w_mode_nxt = 1'b1;
`ifdef FP_SEQ_VERIFY_EN
                w_state_nxt = S_VERIFY;
`else
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
`endif
            end
`ifdef FP_SEQ_VERIFY_EN
            S_VERIFY: begin
                w_wait = 1'b1;
                if (w_term) begin
                    w_match_nxt = (bus.bank_rdata == r_wdata);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = !w_ready_nxt;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_sub   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_mode  <= 1'b1;
            r_add_a <= '0;
            r_add_b <= '0;
`ifdef FP_SEQ_VERIFY_EN
            r_match <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_rs2   <= w_rs2_nxt;
            r_rd    <= w_rd_nxt;
            r_sub   <= w_sub_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_mode  <= w_mode_nxt;
            r_add_a <= w_add_a_nxt;
            r_add_b <= w_add_b_nxt;
`ifdef FP_SEQ_VERIFY_EN
            r_match <= w_match_nxt;
`endif
        end
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bank_addr  = r_addr;
    assign bus.bank_wdata = r_wdata;
    assign bus.bank_we    = r_we;
    assign bus.bank_mode  = r_mode;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
`ifdef FP_SEQ_VERIFY_EN
    assign bus.wb_match   = r_match;
`else
    assign bus.wb_match   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Bench for fp_seq_ctrl: bank and adder models plus a real-arithmetic reference.
// Honours FP_SEQ_VERIFY_EN for the read-back build.
module tb_fp_seq_ctrl;
    import fp_seq_pkg::*;

    localparam int RD_LAT = 2;
`ifdef FP_SEQ_VERIFY_EN
    localparam int LAT = 2 * (RD_LAT + 1) + 2 + (RD_LAT + 1);
`else
    localparam int LAT = 2 * (RD_LAT + 1) + 2;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];
    logic [4:0]  rd_pipe [RD_LAT];
    logic        bd_we;
    logic [4:0]  bd_addr;
    logic [31:0] bd_data;
    logic        corrupt;

    fp_seq_ctrl_if #(.AW(5), .DW(32)) bus ();

    fp_seq_ctrl #(.RD_LAT(RD_LAT), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Reference: rd = rs1 + (sub ? -rs2 : rs2) in plain real arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real rb;
        rb = sub ? -f2r(b) : f2r(b);
        return r2f(f2r(a) + rb);
    endfunction

    function automatic logic [31:0] rnd_val();
        int k;
        k = int'($urandom_range(0, 8000)) - 4000;
        return r2f(real'(k) / 4.0);
    endfunction

    always_comb bus.add_sum = r2f(f2r(bus.add_a) + f2r(bus.add_b));

    // Bank: write on the edge, read data valid RD_LAT cycles after the address.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.bank_we) mem[bus.bank_addr] <= bus.bank_wdata ^ {31'd0, corrupt};
        rd_pipe[0] <= bus.bank_addr;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.bank_rdata = mem[rd_pipe[RD_LAT-1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_we"},    32'(bus.bank_we),   32'd0);
        chk({tag, "_mode"},  32'(bus.bank_mode), 32'd1);
        chk({tag, "_addr"},  32'(bus.bank_addr), 32'd0);
        chk({tag, "_wdata"}, bus.bank_wdata,     32'd0);
        chk({tag, "_add_a"}, bus.add_a,          32'd0);
        chk({tag, "_add_b"}, bus.add_b,          32'd0);
        chk({tag, "_match"}, 32'(bus.wb_match),  32'd0);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Offer a command and return on the negedge just after its accept edge.
    task automatic start_cmd(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic sub);
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd; bus.cmd_sub = sub;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_match_clr", 32'(bus.wb_match), 32'd0);
    endtask

    task automatic wait_done(input bit junk, output int cyc, output logic [4:0] wa,
                             output logic [31:0] wd, output int wecnt, output int modebad);
        cyc = 0; wecnt = 0; modebad = 0; wa = '0; wd = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            cyc = i;
            if (bus.bank_we) begin
                wecnt++; wa = bus.bank_addr; wd = bus.bank_wdata;
            end
            if (bus.bank_mode == bus.bank_we) modebad++;
            if (junk) begin
                bus.cmd_valid = (i <= 3);
                bus.cmd_rs1 = 5'($urandom); bus.cmd_rs2 = 5'($urandom);
                bus.cmd_rd  = 5'($urandom); bus.cmd_sub = 1'($urandom);
            end
            if (bus.done) break;
        end
        if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic sub, output logic [31:0] o_wd, output logic [31:0] o_ab);
        logic [31:0] exp, bexp;
        int cyc, wecnt, modebad;
        logic [4:0] wa;
        exp  = model(ref_mem[rs1], ref_mem[rs2], sub);
        bexp = {ref_mem[rs2][31] ^ sub, ref_mem[rs2][30:0]};
        start_cmd(rs1, rs2, rd, sub);
        wait_done(1'b1, cyc, wa, o_wd, wecnt, modebad);
        o_ab = bus.add_b;
        chk("latency", 32'(cyc), 32'(LAT));
        chk("we_count", 32'(wecnt), 32'd1);
        chk("wb_addr", 32'(wa), 32'(rd));
        chk("wb_data", o_wd, exp);
        chk("mode_vs_we", 32'(modebad), 32'd0);
        chk("add_b", o_ab, bexp);
`ifdef FP_SEQ_VERIFY_EN
        chk("wb_match", 32'(bus.wb_match), 32'(!corrupt));
`else
        chk("wb_match", 32'(bus.wb_match), 32'd0);
`endif
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("mem_rd", mem[rd], exp ^ {31'd0, corrupt});
        ref_mem[rd] = exp ^ {31'd0, corrupt};
    endtask

    initial begin
        logic [31:0] wd, ab, e1, e2;
        int c1, c2, wc, mb;
        logic [4:0] wa;
        int bad_we, bad_done;

        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0; corrupt = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_rd = '0; bus.cmd_sub = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) preload(5'(i), rnd_val());
        preload(5'd1, FP_ONE);
        preload(5'd2, FP_TWO);

        run_cmd(5'd1, 5'd2, 5'd3, 1'b0, wd, ab);
        chk("add_1p2", wd, 32'h4040_0000);
        run_cmd(5'd1, 5'd2, 5'd3, 1'b1, wd, ab);
        chk("sub_1m2", wd, 32'hBF80_0000);
        chk("sub_add_b", ab, 32'hC000_0000);
        preload(5'd4, 32'h4136_0000);
        run_cmd(5'd4, 5'd4, 5'd4, 1'b0, wd, ab);
        chk("alias_rd", wd, 32'h41B6_0000);

        // Back-to-back: valid held high, second command reads the first's result.
        e1 = model(ref_mem[1], ref_mem[2], 1'b0);
        e2 = model(e1, ref_mem[1], 1'b1);
        start_cmd(5'd1, 5'd2, 5'd5, 1'b0);
        bus.cmd_rs1 = 5'd5; bus.cmd_rs2 = 5'd1; bus.cmd_rd = 5'd6; bus.cmd_sub = 1'b1;
        wait_done(1'b0, c1, wa, wd, wc, mb);
        chk("b2b_lat1", 32'(c1), 32'(LAT));
        chk("b2b_data1", wd, e1);
        chk("b2b_we1", 32'(wc), 32'd1);
        chk("b2b_ready_in_done", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("b2b_accept2", 32'(bus.busy), 32'd1);
        wait_done(1'b0, c2, wa, wd, wc, mb);
        chk("b2b_gap", 32'(c2 + 1), 32'(LAT + 1));
        chk("b2b_addr2", 32'(wa), 32'd6);
        chk("b2b_data2", wd, e2);
        @(negedge clk);
        ref_mem[5] = e1; ref_mem[6] = e2;
        chk("b2b_mem5", mem[5], e1);
        chk("b2b_mem6", mem[6], e2);

        // Reset in the middle of the operand-B read.
        start_cmd(5'd7, 5'd8, 5'd9, 1'b0);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        bad_we = 0; bad_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.bank_we) bad_we++;
            if (bus.done) bad_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.bank_we) bad_we++;
            if (bus.done) bad_done++;
        end
        chk("midrst_no_we", 32'(bad_we), 32'd0);
        chk("midrst_no_done", 32'(bad_done), 32'd0);
        chk("midrst_mem9", mem[9], ref_mem[9]);
        run_cmd(5'd7, 5'd8, 5'd9, 1'b0, wd, ab);

        for (int t = 0; t < 12; t++)
            run_cmd(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), wd, ab);

`ifdef FP_SEQ_VERIFY_EN
        corrupt = 1'b1;
        run_cmd(5'd1, 5'd2, 5'd10, 1'b0, wd, ab);
        corrupt = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_seq_ctrl.md
Name: fp_seq_ctrl

Overview:
- Sequencer that executes one FP32 register-to-register operation: rd <= rs1 (+/-) rs2.
- Drives the 32x32 single-port register bank: two reads, then one write-back.
- Presents operands to the combinational FP32 adder and registers its sum.
- Sits between a command source (test harness / future decoder) and the bank + adder pair; replaces the hand-wired initial/compare flow used in board bring-up.

Parameters:
- RD_LAT, 2, bank read latency in cycles (address registered -> bank_rdata valid); legal range 1..7.
- AW, 5, bank address width.
- DW, 32, data width (IEEE-754 single).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready
- cmd_rs1  in  AW  operand A address
- cmd_rs2  in  AW  operand B address
- cmd_rd  in  AW  destination address
- cmd_sub  in  1  1: invert sign of operand B (subtract)
- busy  out  1  command in flight
- done  out  1  one-cycle pulse, write-back committed
- bank_addr  out  AW  bank address
- bank_wdata  out  DW  bank write data
- bank_we  out  1  bank write enable
- bank_mode  out  1  1 = hold/read-only, 0 = write allowed
- bank_rdata  in  DW  bank read data
- add_a  out  DW  adder operand A
- add_b  out  DW  adder operand B
- add_sum  in  DW  adder result (combinational from add_a/add_b)
- wb_match  out  1  read-back check result (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1, busy=0, done=0, bank_we=0, bank_mode=1, bank_addr=0, bank_wdata=0, add_a=0, add_b=0, wb_match=0, counter=0.
- All outputs registered. cmd_ready = (state==IDLE); busy = !cmd_ready.
- States: IDLE, RD_A, RD_B, EXEC, WB (+ VERIFY with macro).
- IDLE: on accept, latch rs2/rd/sub; bank_addr<=rs1; cnt<=0; -> RD_A.
- RD_A: cnt increments each cycle; on edge where cnt==RD_LAT: add_a<=bank_rdata, bank_addr<=rs2, cnt<=0, -> RD_B (RD_LAT+1 cycles).
- RD_B: same; on cnt==RD_LAT: add_b<=bank_rdata with bit31 XOR sub, -> EXEC.
- EXEC (1 cycle): bank_wdata<=add_sum, bank_addr<=rd, bank_we<=1, bank_mode<=0 -> WB.
- WB (1 cycle, bank commits at its edge): bank_we<=0, bank_mode<=1, done<=1, -> IDLE.
- Latency accept-edge -> done high: 2*(RD_LAT+1)+2 = 8 cycles at default.
- bank_we high exactly one cycle per command; bank_mode==0 only in that cycle.
- rd may equal rs1/rs2: reads complete before write, result uses old values.
- cmd_valid during done cycle: accepted (state is IDLE), back-to-back throughput one command per 9 cycles.
- cmd_valid while busy: ignored, no side effect; fields sampled only at accept.
- Reset mid-operation: all state cleared immediately; if asserted before the WB edge no write occurs; no done pulse.
- Adder NaN/Inf/denormal semantics belong to the adder; controller passes bits unmodified except cmd_sub sign flip.

Optional Feature:
- Macro FP_SEQ_VERIFY_EN.
- Defined: WB -> VERIFY instead of IDLE; bank_addr held at rd for RD_LAT+1 cycles; on last cycle wb_match<=(bank_rdata==bank_wdata); done pulses on exit from VERIFY; latency 2*(RD_LAT+1)+2+(RD_LAT+1) = 11 cycles default. wb_match holds until next accept, cleared on accept.
- Undefined: no VERIFY state, wb_match tied 0, latency as above.

Decomposition:
- Package fp_seq_pkg: state enum, FP32 sign bit index (31), default AW/DW constants, FP_ONE/FP_TWO test constants.
- Sub-module fp_seq_wait_cnt: loadable up-counter with terminal flag at RD_LAT; reused by RD_A, RD_B, VERIFY.

Test Plan:
- Preload mem[1]=0x3F800000, mem[2]=0x40000000; cmd rs1=1 rs2=2 rd=3 sub=0 -> bank_we one cycle with addr=3 data=0x40400000; done 8 cycles after accept.
- Same operands, sub=1 -> mem[3]=0xBF800000; add_b observed 0xC0000000.
- rs1=rs2=rd=4, mem[4]=0x41360000 -> mem[4]=0x41B60000; operands read pre-write.
- Back-to-back: cmd_valid held high, two commands -> second accepted in first's done cycle, two done pulses 9 cycles apart; extra cmd_valid while busy ignored.
- Reset low during RD_B -> outputs return to reset values same cycle, no bank_we, no done; next command completes normally.
- FP_SEQ_VERIFY_EN build: first scenario -> wb_match=1, done at 11 cycles; bank model corrupting write -> wb_match=0.
